// File: rtl/sevenseg_scan.sv
// sevenseg_scan -- time-multiplexed driver for an N-digit common-anode
// 7-segment display bank.
//
// Digit data arrives as packed hex nibbles. It is captured atomically into
// shadow registers on a load strobe, decoded to active-low glyphs, and
// scanned out one digit at a time. Each digit is driven for a programmable
// dwell, and an optional all-off gap between digits prevents ghosting.
//
// Parameters:
//   NUM_DIGITS  number of multiplexed digits (1..8)
//   SCAN_DIV    clock cycles each digit is driven (>= 2)
//   GAP_CYCLES  all-off cycles between digits (>= 0, 0 = no gap state)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   load      single-cycle strobe, captures value/dp_in/blank_in
//   value     packed hex nibbles, nibble k = digit k, digit 0 rightmost
//   dp_in     per-digit decimal point request, 1 = lit
//   blank_in  per-digit blank request, 1 = digit dark
//   seg_out   active-low segments, bit7 = dp, bits6..0 = g..a
//   dig_en    active-low digit enables, at most one bit low
//   scan_idx  index of the digit currently driven
//
// Optional feature (compile-time macro SEVENSEG_LZS_EN):
//   Leading-zero suppression. Zero nibbles above the most-significant
//   nonzero nibble are shown blank. Digit 0 is never suppressed. The mask is
//   registered from the shadow value, so it trails a load by one extra cycle.

module sevenseg_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [2:0]              scan_idx
);

  // The counter serves both the dwell and the gap, so it is sized for the
  // longer of the two.
  localparam int CNT_MAX  = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic {
    DRIVE = 1'b0,
    GAP   = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [2:0]              ptr_reg, ptr_next, ptr_adv;

  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [NUM_DIGITS-1:0]   dp_reg;
  logic [NUM_DIGITS-1:0]   blank_reg;

  logic [7:0]              seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]   dig_reg, dig_next;
  logic [2:0]              idx_reg, idx_next;

  logic [NUM_DIGITS-1:0]   lzs_mask;
  logic [7:0]              composed [NUM_DIGITS];
  logic [7:0]              sel_glyph;

  // Active-low glyph for one hex nibble. The dp bit (bit7) is left high.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h98;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // Shadow capture: every field updates on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= '0;
      dp_reg    <= '0;
      blank_reg <= '0;
    end else if (load) begin
      value_reg <= value;
      dp_reg    <= dp_in;
      blank_reg <= blank_in;
    end
  end

`ifdef SEVENSEG_LZS_EN
  logic [NUM_DIGITS-1:0] lzs_next;
  logic [NUM_DIGITS-1:0] lzs_reg;

  // A digit is suppressed when it and every nibble above it are zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzs
    if (gi == 0) begin : g_lsd
      assign lzs_next[gi] = 1'b0;
    end else begin : g_upper
      assign lzs_next[gi] = (value_reg[4*NUM_DIGITS-1:4*gi] == '0);
    end
  end

  // The reset value matches the mask of the all-zero reset shadow, so the
  // display is consistent from the first scanned digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lzs_reg <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
    end else begin
      lzs_reg <= lzs_next;
    end
  end

  assign lzs_mask = lzs_reg;
`else
  assign lzs_mask = '0;
`endif

  // Compose every digit's glyph. The selected one is picked below. Blanking
  // darkens the segments only, so the dp still follows the shadow dp.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_compose
    logic [7:0] raw;
    assign raw = hex_glyph(value_reg[4*gi +: 4]);
    assign composed[gi] = {~dp_reg[gi],
                           (blank_reg[gi] || lzs_mask[gi]) ? 7'h7F : raw[6:0]};
  end

  always_comb begin
    sel_glyph = 8'hFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (ptr_reg == 3'(k)) sel_glyph = composed[k];
    end
  end

  assign ptr_adv = (ptr_reg == 3'(NUM_DIGITS - 1)) ? 3'd0 : ptr_reg + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= DRIVE;
      cnt_reg   <= '0;
      ptr_reg   <= 3'd0;
      seg_reg   <= 8'hFF;
      dig_reg   <= '1;
      idx_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      seg_reg   <= seg_next;
      dig_reg   <= dig_next;
      idx_reg   <= idx_next;
    end
  end

  // Next state plus next outputs. The outputs are registered, so they
  // reflect the current state one cycle later.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    ptr_next   = ptr_reg;
    seg_next   = 8'hFF;
    dig_next   = '1;
    idx_next   = idx_reg;

    case (state_reg)
      DRIVE: begin
        seg_next = sel_glyph;
        idx_next = ptr_reg;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (ptr_reg == 3'(k)) dig_next[k] = 1'b0;
        end
        if (cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
          cnt_next = '0;
          if (GAP_CYCLES == 0) begin
            ptr_next = ptr_adv;
          end else begin
            state_next = GAP;
          end
        end
      end
      GAP: begin
        if (cnt_reg == CNT_W'(GAP_LAST)) begin
          cnt_next   = '0;
          ptr_next   = ptr_adv;
          state_next = DRIVE;
        end
      end
      default: begin
        state_next = DRIVE;
        cnt_next   = '0;
      end
    endcase
  end

  assign seg_out  = seg_reg;
  assign dig_en   = dig_reg;
  assign scan_idx = idx_reg;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan -- self-checking bench for sevenseg_scan.
//
// The reference model works from the scan timeline. The state cycle count
// since reset release, taken modulo the period, gives the digit and the
// phase within it. Glyphs come from a table. Directed scenarios are followed
// by random loads.
`timescale 1ns/1ps

module tb_sevenseg_scan;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int G  = 1;
  localparam int P  = SD + G;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic [7:0]    seg_out;
  logic [3:0]    dig_en;
  logic [2:0]    scan_idx;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int            m_c;
  logic [15:0]   m_val;
  logic [3:0]    m_dp, m_bl, m_mask;
  logic [7:0]    glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                    8'h82, 8'hF8, 8'h80, 8'h98, 8'h88, 8'h83,
                                    8'hC6, 8'hA1, 8'h86, 8'h8E};

  sevenseg_scan #(.NUM_DIGITS(N), .SCAN_DIV(SD), .GAP_CYCLES(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .dp_in    (dp_in),
    .blank_in (blank_in),
    .seg_out  (seg_out),
    .dig_en   (dig_en),
    .scan_idx (scan_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Suppression mask: digit k>0 is dark when the value shifted down by k
  // nibbles is zero.
  function automatic logic [3:0] lzs_of(input logic [15:0] v);
    logic [3:0] m;
    m = '0;
`ifdef SEVENSEG_LZS_EN
    for (int k = 1; k < N; k++) m[k] = ((v >> (4 * k)) == 16'd0);
`endif
    return m;
  endfunction

  function automatic int cur_digit();
    return (m_c % (N * P)) / P;
  endfunction

  function automatic int cur_phase();
    return (m_c % (N * P)) % P;
  endfunction

  task automatic model_reset();
    m_c    = 0;
    m_val  = '0;
    m_dp   = '0;
    m_bl   = '0;
    m_mask = lzs_of(16'h0000);
  endtask

  // One clock edge: predict, clock, update the model, compare.
  task automatic do_edge();
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic [3:0] nmask;
    int         d;
    bit         drv;
    int         zeros;
    d   = cur_digit();
    drv = (cur_phase() < SD);
    e_seg = 8'hFF;
    e_dig = 4'hF;
    if (drv) begin
      e_seg = glyph_tab[(m_val >> (4 * d)) & 16'hF];
      if (m_bl[d] || m_mask[d]) e_seg[6:0] = 7'h7F;
      if (m_dp[d]) e_seg[7] = 1'b0;
      e_dig[d] = 1'b0;
    end
    @(posedge clk);
    nmask = lzs_of(m_val);
    if (load) begin
      m_val = value;
      m_dp  = dp_in;
      m_bl  = blank_in;
    end
    m_mask = nmask;
    m_c++;
    #1;
    check("seg_out", 32'(seg_out), 32'(e_seg));
    check("dig_en", 32'(dig_en), 32'(e_dig));
    if (drv) check("scan_idx", 32'(scan_idx), 32'(d));
    zeros = 0;
    for (int k = 0; k < N; k++) if (!dig_en[k]) zeros++;
    check("dig_en_onehot", 32'(zeros <= 1), 32'd1);
  endtask

  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] dp,
                      input logic [3:0] bl);
    @(negedge clk);
    load     = ld;
    value    = v;
    dp_in    = dp;
    blank_in = bl;
    if (ld) $display("load value=%h dp=%b blank=%b at digit %0d phase %0d",
                     v, dp, bl, cur_digit(), cur_phase());
    do_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, $urandom);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b0;
    model_reset();
    check("release_seg", 32'(seg_out), 32'hFF);
    check("release_dig", 32'(dig_en), 32'hF);
    do_edge();
  endtask

  // Run until the model reaches the given digit and phase, within a bound.
  task automatic run_to(input int d, input int ph);
    int n = 0;
    while (!(cur_digit() == d && cur_phase() == ph) && n < 100) begin
      step(1'b0, '0, '0, '0);
      n++;
    end
    check("run_to_bound", 32'(n < 100), 32'd1);
  endtask

  initial begin
    model_reset();
    // Reset held: outputs at their reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", 32'(seg_out), 32'hFF);
    check("rst_dig", 32'(dig_en), 32'hF);
    check("rst_idx", 32'(scan_idx), 32'd0);

    // Scenario 1: scan of the cleared shadow.
    release_reset();
    idle(21);

    // Scenario 2 and 3: plain value, then dp and blank.
    step(1'b1, 16'h12AF, 4'b0000, 4'b0000);
    idle(45);
    step(1'b1, 16'h12AF, 4'b0100, 4'b1000);
    idle(45);

    // Scenario 4: load while digit1 is mid-dwell.
    step(1'b1, 16'h0000, 4'b0000, 4'b0000);
    run_to(1, 1);
    step(1'b1, 16'h9999, 4'b0000, 4'b0000);
    idle(25);

    // Scenario 5: asynchronous reset during digit2 drive.
    run_to(2, 1);
    @(negedge clk);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg_out), 32'hFF);
    check("async_rst_dig", 32'(dig_en), 32'hF);
    @(posedge clk);
    #1;
    check("held_rst_seg", 32'(seg_out), 32'hFF);
    release_reset();
    idle(21);

    // Scenario 6: leading zeros.
    step(1'b1, 16'h0050, 4'b0000, 4'b0000);
    idle(25);

    // Random loads.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0)
        step(1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      else
        step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
